// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative unsigned multiply/divide and a start/busy/done handshake
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             div_by_zero
);
  localparam logic [3:0] MULTU = 4'hd;
  localparam logic [3:0] DIVU = 4'he;
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] opnd, bb, add, alu, fin_res, fin_hi;
  logic [WIDTH:0] sum, r2, diff;
  logic [SHW-1:0] cnt;
  logic dz, ovf, last, launch, fin;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    dz = opcode == DIVU && b == '0;
    last = cnt == SHW'(WIDTH - 1);
    launch = !busy && start && (opcode == MULTU || (opcode == DIVU && !dz));
    fin = busy ? last : start && !launch;
    state_nx = busy ? (last ? IDLE : state) : !launch ? IDLE : opcode == MULTU ? MUL : DIV;
  end
  always_comb busy = state != IDLE;
  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    r2 = {acc[2*WIDTH-1:WIDTH], acc[M]};
    diff = r2 - {1'b0, opnd};
    acc_nx = state == MUL ? {sum, acc[M:1]} :
             diff[WIDTH] ? {r2[M:0], acc[M-1:0], 1'b0} : {diff[M:0], acc[M-1:0], 1'b1};
  end
  always_comb begin
    bb = opcode == 4'h1 ? ~b + 1'b1 : b;
    add = a + bb;
    ovf = opcode <= 4'h1 && a[M] == bb[M] && add[M] != a[M];
    case (opcode)
      4'h0, 4'h1: alu = add;
      4'h2: alu = a & b;
      4'h3: alu = a | b;
      4'h4: alu = a ^ b;
      4'h5: alu = ~(a | b);
      4'h6: alu = a << b[SHW-1:0];
      4'h7: alu = a >> b[SHW-1:0];
      4'h8: alu = $unsigned($signed(a) >>> b[SHW-1:0]);
      4'h9: alu = WIDTH'(a < b);
      4'ha: alu = a;
      4'hb: alu = b;
      4'hc: alu = b + WIDTH'(8);
      4'he: alu = '1;
      default: alu = '0;
    endcase
    fin_res = busy ? acc_nx[M:0] : alu;
    fin_hi = busy ? acc_nx[2*WIDTH-1:WIDTH] : dz ? a : hi;
  end
  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      opnd <= '0;
      cnt <= '0;
      done <= 1'b0;
      result <= '0;
      hi <= '0;
      z <= 1'b0;
      n <= 1'b0;
      v <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= fin;
      cnt <= busy ? cnt + 1'b1 : '0;
      if (launch) begin
        acc <= {{WIDTH{1'b0}}, opcode == MULTU ? b : a};
        opnd <= opcode == MULTU ? a : b;
      end else if (busy) acc <= acc_nx;
      if (fin) begin
        result <= fin_res;
        hi <= fin_hi;
        z <= fin_res == '0;
        n <= fin_res[M];
        v <= !busy && ovf;
        div_by_zero <= !busy && dz;
      end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a cycle-level behavioural model
module tb_alu_seq;
  localparam int W = 32;
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] opcode = 0;
  logic [W-1:0] a = 0, b = 0;
  logic busy, done, z, n, v, div_by_zero;
  logic [W-1:0] result, hi;
  int checks = 0, errors = 0;
  bit go = 0;
  logic m_busy = 0, m_done = 0, m_z = 0, m_n = 0, m_v = 0, m_dbz = 0;
  logic [W-1:0] m_res = 0, m_hi = 0, p_res = 0, p_hi = 0;
  logic [63:0] prod;
  int m_cnt = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .hi(hi), .z(z), .n(n), .v(v),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [4:0] sh;
    logic [W-1:0] r;
    sh = y[4:0];
    case (op)
      0: r = x + y;
      1: r = x - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = ~(x | y);
      6: r = x << sh;
      7: r = x >> sh;
      8: r = $signed(x) >>> sh;
      9: r = (x < y) ? 1 : 0;
      10: r = x;
      11: r = y;
      12: r = y + 8;
      14: r = '1;
      default: r = 0;
    endcase
    return r;
  endfunction

  // overflow as the true signed range check of a + b', with b' = -b for subtract
  function automatic logic ref_v(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] bp;
    longint s;
    if (op > 1) return 0;
    bp = (op == 1) ? -y : y;
    s = longint'($signed(x)) + longint'($signed(bp));
    return s > 64'sd2147483647 || s < -64'sd2147483648;
  endfunction

  task automatic finish_op(input logic [W-1:0] r, input logic [W-1:0] h, input logic ov, input logic dbz);
    m_res = r;
    m_hi = h;
    m_z = r == 0;
    m_n = r[W-1];
    m_v = ov;
    m_dbz = dbz;
    m_done = 1;
  endtask

  always @(posedge clk) begin
    m_done = 0;
    if (reset) begin
      m_res = 0; m_hi = 0; m_z = 0; m_n = 0; m_v = 0; m_dbz = 0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) finish_op(p_res, p_hi, 0, 0);
    end else if (start) begin
      if (opcode == 13) begin
        prod = 64'(a) * 64'(b);
        p_res = prod[31:0];
        p_hi = prod[63:32];
        m_cnt = W;
      end else if (opcode == 14 && b != 0) begin
        p_res = a / b;
        p_hi = a % b;
        m_cnt = W;
      end else finish_op(ref_op(opcode, a, b), opcode == 14 ? a : m_hi, ref_v(opcode, a, b), opcode == 14);
    end
    m_busy = m_cnt > 0;
  end

  always @(negedge clk)
    if (go) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("result", result, m_res);
      check("hi", hi, m_hi);
      check("z", z, m_z);
      check("n", n, m_n);
      check("v", v, m_v);
      check("div_by_zero", div_by_zero, m_dbz);
    end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1;
    opcode = op;
    a = x;
    b = y;
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    do begin
      @(negedge clk);
      start = 0;
      lat++;
    end while (!done && lat < 60);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 0;
      1: return $urandom % 16;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] ops [4] = '{4'h2, 4'h3, 4'h9, 4'ha};
  logic [W-1:0] b2b_exp [4] = '{32'h0000_F00F, 32'h00F0_FF0F, 32'h1, 32'h0000_FF0F};
  int lat;

  initial begin
    repeat (2) @(negedge clk);
    go = 1;
    check("rst_result", result, 0);
    check("rst_z", z, 0);
    check("rst_done", done, 0);
    reset = 0;
    @(negedge clk);
    issue(0, 32'h7FFF_FFFF, 1); wait_done(0, lat);
    check("add_lat", lat, 1);
    check("add_res", result, 32'h8000_0000);
    check("add_n", n, 1);
    check("add_v", v, 1);
    check("add_z", z, 0);
    issue(1, 5, 5); wait_done(0, lat);
    check("sub_res", result, 0);
    check("sub_z", z, 1);
    check("sub_v", v, 0);
    issue(8, 32'hF000_0000, 32'h24); wait_done(0, lat);
    check("sra", result, 32'hFF00_0000);
    issue(7, 32'hF000_0000, 32'h24); wait_done(0, lat);
    check("srl", result, 32'h0F00_0000);
    issue(6, 1, 32'h21); wait_done(0, lat);
    check("sll", result, 2);
    issue(13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    issue(0, 1, 1);
    wait_done(5, lat);
    check("mul_lat", lat, 33);
    check("mul_hi", hi, 32'hFFFF_FFFE);
    check("mul_lo", result, 1);
    @(negedge clk);
    check("mul_no_extra_done", done, 0);
    issue(14, 100, 7); wait_done(0, lat);
    check("div_lat", lat, 33);
    check("div_q", result, 14);
    check("div_r", hi, 2);
    issue(14, 100, 0); wait_done(0, lat);
    check("dz_lat", lat, 1);
    check("dz_res", result, 32'hFFFF_FFFF);
    check("dz_hi", hi, 100);
    check("dz_flag", div_by_zero, 1);
    issue(0, 3, 4); wait_done(0, lat);
    check("dz_clear", div_by_zero, 0);
    check("dz_hi_keep", hi, 100);
    check("add_after_dz", result, 7);
    issue(13, 123456, 789);
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", result, 0);
    check("abort_hi", hi, 0);
    issue(12, 0, 4); wait_done(0, lat);
    check("b8_lat", lat, 1);
    check("b8_res", result, 12);
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], 32'h0000_FF0F, 32'h00F0_F00F);
      @(negedge clk);
      check("b2b_done", done, 1);
      check("b2b_res", result, b2b_exp[k]);
    end
    start = 0;
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 4) != 0;
      opcode = 4'($urandom);
      a = pick();
      b = pick();
      reset = ($urandom % 300) == 0;
    end
    @(negedge clk);
    start = 0;
    reset = 0;
    repeat (40) @(negedge clk);
    go = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
